clk_div_bank: RTL and testbench

//   Parametrised N-channel clock divider: each channel outputs a 50%-duty divided clock plus a
//   one-cycle tick strobe, with a per-channel half-period programmable at runtime. Reloads are

---
 rtl/clk_div_bank.sv | 97 +++++++++
 tb/tb_clk_div_bank.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// N-channel 50%-duty clock divider bank with runtime half-period reload and a free-running tap.
// Latency: all outputs registered; reloads take effect at the next half-period boundary or on sync.
// Backpressure: none; writes are accepted every cycle and a newer queued value overwrites an older one.
module clk_div_bank #(
  parameter int N_CH = 3,
  parameter int CNT_W = 32,
  parameter logic [N_CH*CNT_W-1:0] DEFAULT_HALF = {32'd4096, 32'd2_000_000, 32'd50_000_000},
  parameter int TAP_W = 21,
  parameter int TAP_BIT = 13,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   en,
  input  logic              sync,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   pending,
  output logic              tap_out
);

  // A zero half-period would never reach a boundary, so it is stored as 1.
  logic [CNT_W-1:0] wr_val;
  assign wr_val = (div_val == '0) ? CNT_W'(1) : div_val;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] pend_val;
    logic [CNT_W-1:0] apply_val;
    logic [CNT_W:0]   cnt_inc;
    logic             wr_hit;
    logic             boundary;
    logic             clk_q;
    logic             tick_q;
    logic             pend_q;

    assign wr_hit    = div_wr && (int'(div_sel) == ch);
    assign apply_val = wr_hit ? wr_val : (pend_q ? pend_val : active);
    assign cnt_inc   = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    // >= rather than == so a lowered half-period below the current count ends this half at once.
    assign boundary  = cnt_inc >= {1'b0, active};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt      <= '0;
        active   <= DEFAULT_HALF[ch*CNT_W +: CNT_W];
        pend_val <= '0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
        pend_q   <= 1'b0;
      end else if (sync) begin
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        active <= apply_val;
        pend_q <= 1'b0;
      end else if (!en[ch]) begin
        tick_q <= 1'b0;
        if (wr_hit) begin
          active <= wr_val;
          pend_q <= 1'b0;
        end
      end else if (boundary) begin
        cnt    <= '0;
        clk_q  <= ~clk_q;
        tick_q <= ~clk_q;
        active <= apply_val;
        pend_q <= 1'b0;
      end else begin
        cnt    <= cnt_inc[CNT_W-1:0];
        tick_q <= 1'b0;
        if (wr_hit) begin
          pend_val <= wr_val;
          pend_q   <= 1'b1;
        end
      end
    end

    assign clk_out[ch] = clk_q;
    assign tick[ch]    = tick_q;
    assign pending[ch] = pend_q;
  end

  logic [TAP_W-1:0] tap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tap <= '0;
    else        tap <= tap + TAP_W'(1);
  end

  assign tap_out = tap[TAP_BIT];

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: default periods, queued reload, zero clamp, sync, enable gating,
// ignored out-of-range select, async reset mid-count and the tap output period.
module tb_clk_div_bank;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] en;
  logic       sync;
  logic       div_wr;
  logic [1:0] div_sel;
  logic [7:0] div_val;
  logic [2:0] clk_out;
  logic [2:0] tick;
  logic [2:0] pending;
  logic       tap_out;

  int n_chk  = 0;
  int n_fail = 0;

  clk_div_bank #(
    .N_CH(3), .CNT_W(8), .DEFAULT_HALF({8'd2, 8'd3, 8'd5}), .TAP_W(21), .TAP_BIT(13)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .div_wr(div_wr), .div_sel(div_sel),
    .div_val(div_val), .clk_out(clk_out), .tick(tick), .pending(pending), .tap_out(tap_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected square wave / tick of a channel that has run k cycles from a cleared state.
  function automatic logic exp_clk(input int k, input int h);
    return ((k / h) % 2) == 1;
  endfunction

  function automatic logic exp_tick(input int k, input int h);
    return (k > 0) && ((k % (2 * h)) == h);
  endfunction

  function automatic logic [2:0] exp_vec(input int k, input int h0, input int h1, input int h2,
                                         input bit want_tick);
    logic [2:0] v;
    if (want_tick) v = {exp_tick(k, h2), exp_tick(k, h1), exp_tick(k, h0)};
    else           v = {exp_clk(k, h2), exp_clk(k, h1), exp_clk(k, h0)};
    return v;
  endfunction

  initial begin
    int hi [3];
    int tk [3];
    logic [7:0] t2_pend, t2_clk, t2_tick;
    logic [13:0] t5_clk, t5_tick;

    rst_n = 1'b0; en = 3'b111; sync = 1'b0; div_wr = 1'b0; div_sel = '0; div_val = '0;
    step(); step();
    check("rst clk_out", 32'(clk_out), 32'h0);
    check("rst tick", 32'(tick), 32'h0);
    check("rst pending", 32'(pending), 32'h0);
    check("rst tap_out", 32'(tap_out), 32'h0);
    rst_n = 1'b1;

    // Default half-periods 5/3/2, all enabled.
    for (int c = 0; c < 3; c++) begin hi[c] = 0; tk[c] = 0; end
    for (int k = 1; k <= 60; k++) begin
      step();
      check($sformatf("t1 clk k=%0d", k), 32'(clk_out), 32'(exp_vec(k, 5, 3, 2, 1'b0)));
      check($sformatf("t1 tick k=%0d", k), 32'(tick), 32'(exp_vec(k, 5, 3, 2, 1'b1)));
      for (int c = 0; c < 3; c++) begin
        hi[c] += int'(clk_out[c]);
        tk[c] += int'(tick[c]);
      end
    end
    check("t1 duty ch0", hi[0], 30);
    check("t1 duty ch1", hi[1], 30);
    check("t1 duty ch2", hi[2], 30);
    check("t1 ticks ch0", tk[0], 6);
    check("t1 ticks ch1", tk[1], 10);
    check("t1 ticks ch2", tk[2], 15);

    // Queued reload on ch0: written at cnt=1, applied at the boundary after cnt=4.
    step();
    check("t2 pre clk0", 32'(clk_out[0]), 32'h0);
    div_wr = 1'b1; div_sel = 2'd0; div_val = 8'd2;
    t2_pend = 8'b0000_0111;
    t2_clk  = 8'b1001_1000;
    t2_tick = 8'b1000_1000;
    for (int j = 0; j < 8; j++) begin
      step();
      div_wr = 1'b0;
      check($sformatf("t2 pending0 j=%0d", j), 32'(pending[0]), 32'(t2_pend[j]));
      check($sformatf("t2 clk0 j=%0d", j), 32'(clk_out[0]), 32'(t2_clk[j]));
      check($sformatf("t2 tick0 j=%0d", j), 32'(tick[0]), 32'(t2_tick[j]));
    end

    // sync with ch0 high, plus a same-cycle zero write to ch1 (clamped to H=1).
    sync = 1'b1; div_wr = 1'b1; div_sel = 2'd1; div_val = 8'd0;
    step();
    sync = 1'b0; div_wr = 1'b0;
    check("t4 sync clk_out", 32'(clk_out), 32'h0);
    check("t4 sync tick", 32'(tick), 32'h0);
    check("t4 sync pending", 32'(pending), 32'h0);
    for (int m = 1; m <= 15; m++) begin
      step();
      check($sformatf("t4 clk m=%0d", m), 32'(clk_out), 32'(exp_vec(m, 2, 1, 2, 1'b0)));
      check($sformatf("t4 tick m=%0d", m), 32'(tick), 32'(exp_vec(m, 2, 1, 2, 1'b1)));
    end

    // ch2 disabled for 7 cycles with clk_out high; a write while disabled loads H=4 at once.
    en = 3'b011;
    t5_clk  = 14'b10_0001_1111_1111;
    t5_tick = 14'b10_0000_0000_0000;
    for (int j = 0; j < 14; j++) begin
      step();
      check($sformatf("t5 clk2 j=%0d", j), 32'(clk_out[2]), 32'(t5_clk[j]));
      check($sformatf("t5 tick2 j=%0d", j), 32'(tick[2]), 32'(t5_tick[j]));
      if (j == 2) check("t5 pending2 disabled", 32'(pending[2]), 32'h0);
      div_wr = (j == 1);
      div_sel = 2'd2; div_val = 8'd4;
      if (j == 6) en = 3'b111;
    end

    // Queue a reload on ch2, then an out-of-range select that must be ignored.
    div_wr = 1'b1; div_sel = 2'd2; div_val = 8'd3;
    step();
    check("t6 pending set", 32'(pending), 32'h4);
    div_sel = 2'd3; div_val = 8'd1;
    step();
    div_wr = 1'b0;
    check("t6 sel3 ignored", 32'(pending), 32'h4);

    // Asynchronous reset between clock edges.
    #3 rst_n = 1'b0;
    #1;
    check("t6 async clk_out", 32'(clk_out), 32'h0);
    check("t6 async tick", 32'(tick), 32'h0);
    check("t6 async pending", 32'(pending), 32'h0);
    #3 rst_n = 1'b1;
    for (int k = 1; k <= 16384; k++) begin
      step();
      if (k <= 12) begin
        check($sformatf("t6 clk k=%0d", k), 32'(clk_out), 32'(exp_vec(k, 5, 3, 2, 1'b0)));
        check($sformatf("t6 tick k=%0d", k), 32'(tick), 32'(exp_vec(k, 5, 3, 2, 1'b1)));
      end
      if (k == 8191)  check("tap k=8191", 32'(tap_out), 32'h0);
      if (k == 8192)  check("tap k=8192", 32'(tap_out), 32'h1);
      if (k == 16383) check("tap k=16383", 32'(tap_out), 32'h1);
      if (k == 16384) check("tap k=16384", 32'(tap_out), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
